protect_resp: RTL and testbench
===============================

Name: protect_resp

Overview:
- Fault-response controller on the consuming side of the debounced protection flags.
- Takes the filtered over-temp/HV-cap trip flag (protect_en, 1 = protect) and the sensor-present flag (SensorOK_en, 1 = connected).
- Owns the HV supply enable and the transmit-pulse gate; trips them off on fault, runs a cooldown/auto-retry sequence, and locks out after repeated faults until host clear.
- Sits between the protect filter and the pulser/HV driver logic.

Parameters:
- HOLD_CYC, 24'd1000000: healthy cycles required before (re)enabling HV, and healthy RUN cycles required to reset the retry count.
- MAX_RETRY, 4'd3: auto-retries allowed before lockout. Range 1..15.
- MAX_PULSE, 8'd200: max consecutive pulse_gate-high cycles; used only with the optional feature.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- protect_en, in, 1: 1 = protection fault active.
- SensorOK_en, in, 1: 1 = sensor connected; 0 = fault.
- pulse_req, in, 1: upstream transmit request, level.
- fault_clr, in, 1: host clear; single-cycle pulse.
- hv_on, out, 1: HV supply enable.
- pulse_gate, out, 1: gated transmit enable to pulser.
- fault_latched, out, 1: lockout indicator.
- fault_code, out, 2: bit0 = protect fault, bit1 = sensor fault; holds the cause of the most recent trip.
- retry_cnt, out, 4: trips since last healthy period.
- state_o, out, 3: current state, for debug/status readback.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; internal hold counter 0.
- healthy = ~protect_en & SensorOK_en, sampled each posedge. All outputs are registered.
- States (state_o encoding): IDLE=0, RUN=1, TRIP=2, COOL=3, LOCK=4. Unused codes go to IDLE with outputs cleared.
- IDLE:
  - hv_on=0, pulse_gate=0.
  - Hold counter increments while healthy; any unhealthy cycle clears it to 0.
  - When counter == HOLD_CYC-1 and healthy: go to RUN, clear counter. hv_on goes 1 on that edge.
- RUN:
  - hv_on=1.
  - pulse_gate <= pulse_req & healthy (1-cycle latency from pulse_req).
  - Unhealthy sample: go to TRIP. On that same edge: hv_on<=0, pulse_gate<=0, fault_code<={~SensorOK_en, protect_en}, retry_cnt saturating +1 at 15.
  - Healthy: counter increments. At HOLD_CYC-1, retry_cnt<=0 and counter stops (no wrap).
  - Counter is cleared on entry to RUN.
- TRIP: exactly one cycle, outputs low. Next state is LOCK if retry_cnt > MAX_RETRY, else COOL. Counter cleared.
- COOL:
  - Outputs low.
  - Counter increments while healthy; an unhealthy cycle clears it and updates fault_code with the new cause. retry_cnt is unchanged in COOL.
  - At HOLD_CYC-1 and healthy: go to RUN.
- LOCK:
  - fault_latched=1; hv_on=0, pulse_gate=0.
  - fault_clr & healthy in the same cycle: go to IDLE, retry_cnt<=0, fault_latched<=0, fault_code<=0.
  - fault_clr while unhealthy is ignored.
- fault_clr in any state other than LOCK has no effect.
- Reset asserted mid-operation: immediate output drop to reset values, independent of clk.
- Counter is 24 bits and never wraps. HOLD_CYC=0 is treated as 1.

Optional Feature:
- Macro: PROTECT_RESP_PULSE_LIMIT_EN.
- Defined:
  - An 8-bit width counter runs while pulse_gate=1.
  - When it reaches MAX_PULSE, pulse_gate is forced 0 until pulse_req has been sampled 0 for at least one cycle.
  - Exceeding the limit does not trip and does not change state.
- Not defined: pulse_gate follows pulse_req unconditionally in RUN; no counter logic is synthesized.

Test Plan:
Bench parameters for all scenarios: HOLD_CYC=10, MAX_RETRY=2.
1. Power-up: release reset with healthy held. Expect hv_on=1 on the 10th posedge after release; state_o=1. pulse_req=1 gives pulse_gate=1 on the following edge.
2. Startup glitch: protect_en=1 for 1 cycle at IDLE cycle 5. Expect the IDLE counter to restart and hv_on to rise 10 healthy cycles after the glitch.
3. Single trip: in RUN with pulse_gate=1, drive protect_en=1 for 3 cycles. Expect hv_on=0 and pulse_gate=0 one edge after first sample; fault_code=01; retry_cnt=1; TRIP then COOL. hv_on returns 10 cycles after protect_en falls.
4. Lockout: SensorOK_en=0 pulses, each after RUN is re-entered, 3 times in a row. Expect fault_code=10 and retry_cnt=3 → LOCK, fault_latched=1. fault_clr while SensorOK_en=0 is ignored; fault_clr while healthy → IDLE with retry_cnt=0, fault_code=00.
5. Retry reset: one trip, recover, then stay healthy 10 cycles in RUN. Expect retry_cnt returns 0. A later trip gives retry_cnt=1, not 2.
6. With PROTECT_RESP_PULSE_LIMIT_EN and MAX_PULSE=4: hold pulse_req=1 for 10 cycles. Expect pulse_gate high exactly 4 cycles then 0. After pulse_req goes 0 for 1 cycle and back to 1, pulse_gate rises again.

Source files
------------

// File: rtl/protect_resp.sv
// rtl/protect_resp.sv - HV/pulse fault-response controller with cooldown, auto-retry and lockout
// Optional pulse-width limiter: define PROTECT_RESP_PULSE_LIMIT_EN.
module protect_resp #(
    parameter logic [23:0] HOLD_CYC  = 24'd1000000,
    parameter logic [3:0]  MAX_RETRY = 4'd3,
    parameter logic [7:0]  MAX_PULSE = 8'd200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       protect_en,
    input  logic       SensorOK_en,
    input  logic       pulse_req,
    input  logic       fault_clr,
    output logic       hv_on,
    output logic       pulse_gate,
    output logic       fault_latched,
    output logic [1:0] fault_code,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        TRIP = 3'd2,
        COOL = 3'd3,
        LOCK = 3'd4
    } state_t;

    // HOLD_CYC of zero behaves as one healthy cycle
    localparam logic [23:0] HOLD_LAST = (HOLD_CYC == 24'd0) ? 24'd0 : HOLD_CYC - 24'd1;

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic        hv_n, gate_n, lat_n;
    logic [1:0]  code_n;
    logic [3:0]  retry_n;
    logic        healthy;
    logic        gate_ok;

    assign healthy = ~protect_en & SensorOK_en;
    assign state_o = state;

`ifdef PROTECT_RESP_PULSE_LIMIT_EN
    logic [7:0] pcnt, pcnt_n;
    logic       blk, blk_n;

    assign gate_ok = pulse_req & ~blk & (pcnt < MAX_PULSE);

    always_comb begin
        pcnt_n = gate_n ? pcnt + 8'd1 : 8'd0;
        blk_n  = blk;
        if (!pulse_req)
            blk_n = 1'b0;
        else if (pcnt >= MAX_PULSE)
            blk_n = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= 8'd0;
            blk  <= 1'b0;
        end else begin
            pcnt <= pcnt_n;
            blk  <= blk_n;
        end
    end
`else
    assign gate_ok = pulse_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hv_n    = 1'b0;
        gate_n  = 1'b0;
        lat_n   = 1'b0;
        code_n  = fault_code;
        retry_n = retry_cnt;
        case (state)
            IDLE: begin
                if (!healthy) begin
                    cnt_n = 24'd0;
                end else if (cnt == HOLD_LAST) begin
                    state_n = RUN;
                    cnt_n   = 24'd0;
                    hv_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 24'd1;
                end
            end
            RUN: begin
                if (!healthy) begin
                    state_n = TRIP;
                    cnt_n   = 24'd0;
                    code_n  = {~SensorOK_en, protect_en};
                    retry_n = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;
                end else begin
                    hv_n   = 1'b1;
                    gate_n = gate_ok;
                    // a full healthy hold in RUN forgives earlier trips
                    if (cnt == HOLD_LAST)
                        retry_n = 4'd0;
                    else
                        cnt_n = cnt + 24'd1;
                end
            end
            TRIP: begin
                cnt_n = 24'd0;
                if (retry_cnt > MAX_RETRY) begin
                    state_n = LOCK;
                    lat_n   = 1'b1;
                end else begin
                    state_n = COOL;
                end
            end
            COOL: begin
                if (!healthy) begin
                    cnt_n  = 24'd0;
                    code_n = {~SensorOK_en, protect_en};
                end else if (cnt == HOLD_LAST) begin
                    state_n = RUN;
                    cnt_n   = 24'd0;
                    hv_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 24'd1;
                end
            end
            LOCK: begin
                cnt_n = 24'd0;
                lat_n = 1'b1;
                if (fault_clr && healthy) begin
                    state_n = IDLE;
                    lat_n   = 1'b0;
                    retry_n = 4'd0;
                    code_n  = 2'b00;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 24'd0;
                code_n  = 2'b00;
                retry_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= 24'd0;
            hv_on         <= 1'b0;
            pulse_gate    <= 1'b0;
            fault_latched <= 1'b0;
            fault_code    <= 2'b00;
            retry_cnt     <= 4'd0;
        end else begin
            cnt           <= cnt_n;
            hv_on         <= hv_n;
            pulse_gate    <= gate_n;
            fault_latched <= lat_n;
            fault_code    <= code_n;
            retry_cnt     <= retry_n;
        end
    end

endmodule

// File: tb/tb_protect_resp.sv
// tb/tb_protect_resp.sv - scoreboard testbench for protect_resp
module tb_protect_resp;

    localparam int F_HV = 0, F_GATE = 1, F_LAT = 2, F_CODE = 3, F_RETRY = 4, F_STATE = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       protect_en = 1'b0;
    logic       SensorOK_en = 1'b1;
    logic       pulse_req = 1'b0;
    logic       fault_clr = 1'b0;
    logic       hv_on, pulse_gate, fault_latched;
    logic [1:0] fault_code;
    logic [3:0] retry_cnt;
    logic [2:0] state_o;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int    cyc;
        string name;
        int    field;
        int    val;
    } exp_t;

    exp_t sb[$];

    protect_resp #(
        .HOLD_CYC (24'd10),
        .MAX_RETRY(4'd2),
        .MAX_PULSE(8'd4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .protect_en   (protect_en),
        .SensorOK_en  (SensorOK_en),
        .pulse_req    (pulse_req),
        .fault_clr    (fault_clr),
        .hv_on        (hv_on),
        .pulse_gate   (pulse_gate),
        .fault_latched(fault_latched),
        .fault_code   (fault_code),
        .retry_cnt    (retry_cnt),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int f);
        case (f)
            F_HV:    return int'(hv_on);
            F_GATE:  return int'(pulse_gate);
            F_LAT:   return int'(fault_latched);
            F_CODE:  return int'(fault_code);
            F_RETRY: return int'(retry_cnt);
            default: return int'(state_o);
        endcase
    endfunction

    // monitor: compare every expectation due at or before this cycle
    always @(negedge clk) begin
        int i;
        int a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                a = actual(sb[i].field);
                checks++;
                if (a !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %0d expected %0d", sb[i].name, cyc, a, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int d, input string nm, input int f, input int v);
        exp_t e;
        e.cyc   = cyc + d;
        e.name  = nm;
        e.field = f;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // reset state
        step(2);
        expect_at(0, "rst_hv", F_HV, 0);
        expect_at(0, "rst_gate", F_GATE, 0);
        expect_at(0, "rst_lat", F_LAT, 0);
        expect_at(0, "rst_code", F_CODE, 0);
        expect_at(0, "rst_retry", F_RETRY, 0);
        expect_at(0, "rst_state", F_STATE, 0);

        // power-up: hv_on on the 10th edge after release
        reset_n = 1'b1;
        expect_at(9, "pwr_hv_early", F_HV, 0);
        expect_at(10, "pwr_hv", F_HV, 1);
        expect_at(10, "pwr_state", F_STATE, 1);
        step(10);
        pulse_req = 1'b1;
        expect_at(1, "pwr_gate", F_GATE, 1);
        step(1);

        // single protect trip of 3 cycles
        protect_en = 1'b1;
        expect_at(1, "trip_hv", F_HV, 0);
        expect_at(1, "trip_gate", F_GATE, 0);
        expect_at(1, "trip_code", F_CODE, 1);
        expect_at(1, "trip_retry", F_RETRY, 1);
        expect_at(1, "trip_state", F_STATE, 2);
        expect_at(2, "trip_cool", F_STATE, 3);
        step(3);
        protect_en = 1'b0;
        expect_at(9, "cool_hv_early", F_HV, 0);
        expect_at(10, "cool_hv", F_HV, 1);
        expect_at(10, "cool_state", F_STATE, 1);
        expect_at(10, "cool_retry", F_RETRY, 1);
        step(10);

        // retry count forgiven after a full healthy hold in RUN
        expect_at(1, "run_gate", F_GATE, 1);
        expect_at(9, "rr_retry_held", F_RETRY, 1);
        expect_at(10, "rr_retry_clr", F_RETRY, 0);
        step(10);

        // three sensor faults in a row lead to lockout
        for (int k = 1; k <= 2; k++) begin
            SensorOK_en = 1'b0;
            expect_at(1, "sens_code", F_CODE, 2);
            expect_at(1, "sens_retry", F_RETRY, k);
            expect_at(1, "sens_state", F_STATE, 2);
            expect_at(2, "sens_cool", F_STATE, 3);
            expect_at(11, "sens_hv_early", F_HV, 0);
            expect_at(12, "sens_hv", F_HV, 1);
            step(1);
            SensorOK_en = 1'b1;
            step(11);
        end
        SensorOK_en = 1'b0;
        expect_at(1, "lock_retry", F_RETRY, 3);
        expect_at(2, "lock_state", F_STATE, 4);
        expect_at(2, "lock_lat", F_LAT, 1);
        expect_at(2, "lock_hv", F_HV, 0);
        step(2);
        fault_clr = 1'b1;
        expect_at(1, "clr_ign_lat", F_LAT, 1);
        expect_at(1, "clr_ign_state", F_STATE, 4);
        step(1);
        fault_clr = 1'b0;
        SensorOK_en = 1'b1;
        step(1);
        fault_clr = 1'b1;
        expect_at(1, "clr_state", F_STATE, 0);
        expect_at(1, "clr_lat", F_LAT, 0);
        expect_at(1, "clr_retry", F_RETRY, 0);
        expect_at(1, "clr_code", F_CODE, 0);
        step(1);
        fault_clr = 1'b0;

        // startup glitch at IDLE cycle 5 restarts the hold count
        step(4);
        protect_en = 1'b1;
        step(1);
        protect_en = 1'b0;
        expect_at(9, "glitch_hv_early", F_HV, 0);
        expect_at(10, "glitch_hv", F_HV, 1);
        expect_at(10, "glitch_state", F_STATE, 1);
        step(10);

`ifdef PROTECT_RESP_PULSE_LIMIT_EN
        pulse_req = 1'b0;
        step(2);
        pulse_req = 1'b1;
        expect_at(1, "plim_first", F_GATE, 1);
        expect_at(4, "plim_last", F_GATE, 1);
        expect_at(5, "plim_cut", F_GATE, 0);
        expect_at(10, "plim_held", F_GATE, 0);
        expect_at(10, "plim_state", F_STATE, 1);
        step(10);
        pulse_req = 1'b0;
        step(1);
        pulse_req = 1'b1;
        expect_at(1, "plim_rearm", F_GATE, 1);
        step(1);
`endif

        // asynchronous reset drops outputs before the next edge
        expect_at(0, "pre_arst_hv", F_HV, 1);
        step(1);
        reset_n = 1'b0;
        expect_at(0, "arst_hv", F_HV, 0);
        expect_at(0, "arst_gate", F_GATE, 0);
        expect_at(0, "arst_state", F_STATE, 0);
        step(2);

        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
